// File: rtl/memory_sb.sv
// memory_sb: word-organised data RAM behind a FIFO store buffer, byte/half/word loads and stores.
// Optional MEM_SB_BYPASS_EN: loads merge buffered bytes (youngest wins) instead of stalling on a hit.
module memory_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          alu_result_m,
  input  logic [WIDTH-1:0]          write_data_m,
  input  logic                      mem_write_m,
  input  logic                      mem_read_m,
  input  logic [2:0]                funct3_m,
  input  logic                      fwd_ls_w,
  input  logic [WIDTH-1:0]          result_w,
  output logic [WIDTH-1:0]          read_data_m,
  output logic                      stall_m,
  output logic [$clog2(SB_DEPTH):0] sb_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem_r     [DEPTH];
  logic [AW-1:0]    sb_idx_r  [SB_DEPTH];
  logic [WIDTH-1:0] sb_data_r [SB_DEPTH];
  logic [NB-1:0]    sb_mask_r [SB_DEPTH];
  logic [PW-1:0]    head_r, tail_r;
  logic [CW-1:0]    count_r;

  logic [AW-1:0]    idx_s;
  logic [1:0]       off_s;
  logic [WIDTH-1:0] st_src_s, st_data_s, ld_word_s;
  logic [NB-1:0]    st_mask_s;
  logic             st_ok_s, load_stall_s, full_s, push_s, drain_s;
  logic [7:0]       ld_byte_s;
  logic [15:0]      ld_half_s;
  logic [PW-1:0]    pos_s;
  logic             unused_addr_s;

  assign idx_s         = alu_result_m[AW+1:2];
  assign off_s         = alu_result_m[1:0];
  assign unused_addr_s = ^alu_result_m[WIDTH-1:AW+2];
  assign sb_count      = count_r;

  // Store lane placement and byte mask; halfword/word offsets are aligned down
  always_comb begin
    st_src_s  = fwd_ls_w ? result_w : write_data_m;
    st_ok_s   = 1'b1;
    st_mask_s = '0;
    st_data_s = '0;
    case (funct3_m)
      3'b000: begin
        st_mask_s = {{(NB-1){1'b0}}, 1'b1} << off_s;
        st_data_s = WIDTH'(st_src_s[7:0]) << {off_s, 3'b000};
      end
      3'b001: begin
        st_mask_s = {{(NB-2){1'b0}}, 2'b11} << {off_s[1], 1'b0};
        st_data_s = WIDTH'(st_src_s[15:0]) << {off_s[1], 4'b0000};
      end
      3'b010: begin
        st_mask_s = '1;
        st_data_s = st_src_s;
      end
      default: st_ok_s = 1'b0;
    endcase
  end

  // Buffer scan from oldest to youngest: merge bytes or flag a load hit
  always_comb begin
    load_stall_s = 1'b0;
    ld_word_s    = mem_r[idx_s];
    pos_s        = head_r;
    for (int k = 0; k < SB_DEPTH; k++) begin
      pos_s = head_r + PW'(k);
      if ((CW'(k) < count_r) && (sb_idx_r[pos_s] == idx_s)) begin
`ifdef MEM_SB_BYPASS_EN
        for (int b = 0; b < NB; b++) begin
          ld_word_s[8*b +: 8] = sb_mask_r[pos_s][b] ? sb_data_r[pos_s][8*b +: 8] : ld_word_s[8*b +: 8];
        end
`else
        load_stall_s = mem_read_m;
`endif
      end else begin
        load_stall_s = load_stall_s;
      end
    end
  end

  // Lane select and sign/zero extension of the load word
  always_comb begin
    read_data_m = '0;
    ld_byte_s   = 8'(ld_word_s >> {off_s, 3'b000});
    ld_half_s   = 16'(ld_word_s >> {off_s[1], 4'b0000});
    case (funct3_m)
      3'b000:  read_data_m = {{(WIDTH-8){ld_byte_s[7]}}, ld_byte_s};
      3'b001:  read_data_m = {{(WIDTH-16){ld_half_s[15]}}, ld_half_s};
      3'b010:  read_data_m = ld_word_s;
      3'b100:  read_data_m = {{(WIDTH-8){1'b0}}, ld_byte_s};
      3'b101:  read_data_m = {{(WIDTH-16){1'b0}}, ld_half_s};
      default: read_data_m = '0;
    endcase
  end

  // A stalled load leaves the single RAM port free, so draining continues under it
  always_comb begin
    full_s  = (count_r == CW'(SB_DEPTH));
    stall_m = (mem_write_m && full_s) || load_stall_s;
    push_s  = mem_write_m && st_ok_s && !stall_m;
    drain_s = (count_r != '0) && (!mem_read_m || load_stall_s);
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s)  tail_r <= tail_r + PW'(1);
      if (drain_s) head_r <= head_r + PW'(1);
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage and byte-enabled RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_idx_r[tail_r]  <= idx_s;
      sb_data_r[tail_r] <= st_data_s;
      sb_mask_r[tail_r] <= st_mask_s;
    end
    if (drain_s) begin
      for (int b = 0; b < NB; b++) begin
        if (sb_mask_r[head_r][b]) mem_r[sb_idx_r[head_r]][8*b +: 8] <= sb_data_r[head_r][8*b +: 8];
      end
    end
  end
endmodule

// File: doc/memory_sb.md
Name: memory_sb

Overview:
- Parametrised memory-stage successor: a word-organised data RAM behind a FIFO store buffer.
- Adds byte/halfword/word loads and stores with sign/zero extension.
- Keeps the write-back-to-store-data forwarding path.
- Sits between execute/memory pipeline register and write-back; asserts a stall when the buffer cannot accept a store or a load must wait.

Parameters:
- WIDTH, 32: data and address width.
- DEPTH, 1024: RAM depth in WIDTH-bit words (power of 2).
- SB_DEPTH, 4: store-buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_result_m  in  WIDTH  byte address
- write_data_m  in  WIDTH  store data from pipeline
- mem_write_m  in  1  store request
- mem_read_m  in  1  load request
- funct3_m  in  3  access size/sign (RV32I encoding)
- fwd_ls_w  in  1  select result_w as store data
- result_w  in  WIDTH  write-back value for load-store forwarding
- read_data_m  out  WIDTH  extended load data
- stall_m  out  1  pipeline must hold the memory-stage instruction
- sb_count  out  $clog2(SB_DEPTH)+1  buffer occupancy (debug)

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-low. clk and rst_n as named above.
- Reset clears head, tail and count. sb_count=0, stall_m=0.
- RAM contents are not reset. read_data_m is combinational with no reset value.
- Addressing:
  - word index = alu_result_m[$clog2(DEPTH)+1:2], wrapping modulo DEPTH.
  - byte offset = alu_result_m[1:0].
  - Misaligned halfword/word accesses are aligned down (offset bits ignored).
- Store data = fwd_ls_w ? result_w : write_data_m, shifted into lane position.
- Byte mask by funct3 and offset:
  - SB (000): one byte.
  - SH (001): bytes [1:0] or [3:2].
  - SW (010): all four.
  - Other funct3 with mem_write_m: no store is pushed.
- Push: mem_write_m && count<SB_DEPTH enqueues {word index, lane data, mask} at tail on the clock edge.
- Drain: when count>0 and mem_read_m==0 (RAM is single-port), the head entry is written to RAM with byte-enable mask and head advances. Push and drain may occur in the same cycle; count is unchanged.
- stall_m asserts combinationally:
  - whenever mem_write_m && count==SB_DEPTH, regardless of a same-cycle drain;
  - plus the load-hit condition when the optional feature is disabled.
- A store is never pushed in a cycle where stall_m=1.
- Load path:
  - RAM word read combinationally.
  - With the optional feature enabled, each byte is overridden by the youngest valid buffer entry with matching index and mask bit.
  - Then lane select and extension: LB 000 sign, LH 001 sign, LW 010, LBU 100 zero, LHU 101 zero. Other funct3 returns 0.
- Pointers wrap modulo SB_DEPTH. count is never above SB_DEPTH nor below 0.
- Reset mid-operation: un-drained stores are discarded and the RAM keeps only drained data.

Optional Feature:
- Macro: MEM_SB_BYPASS_EN.
- Defined: loads merge per-byte from the buffer, youngest entry wins; no load stall.
- Undefined:
  - A load whose word index matches any valid entry asserts stall_m.
  - Drain is permitted during that stalled load cycle.
  - stall_m drops once no matching entry remains.
  - Merge logic is omitted.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x10, one idle cycle, LW @0x10 -> read_data_m=0xDEADBEEF, sb_count returns to 0.
- After SW 0x80FF7F01 @0x20: LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x20 -> 0x00007F01; LHU @0x22 -> 0x000080FF.
- SB 0xAA @0x31 with fwd_ls_w=1, result_w=0x000000AA, write_data_m=0x55 -> after drain, LW @0x30 shows byte1=0xAA and other bytes unchanged.
- Hold mem_read_m=1 for 4 cycles while issuing SW each cycle -> sb_count=4. Fifth SW -> stall_m=1 for one cycle, then accepted; drain order matches issue order.
- Buffer 0x11223344 @0x40 while loads block the drain, then LW @0x40:
  - MEM_SB_BYPASS_EN defined -> 0x11223344, stall_m=0.
  - Undefined -> stall_m=1 until drained, then 0x11223344.
- Assert rst_n=0 with 3 entries buffered -> sb_count=0 immediately. Loads of those addresses return the pre-store RAM values.
